// File: rtl/dispense_sequencer.sv
// dispense_sequencer: timed, interlocked dispense cycle driving the valve
// relay request. A debounced push button or a one-cycle command starts a
// dispense. The dispense only starts when a debounced cup sensor reports a
// cup. Every dispense is followed by an enforced cooldown.
module dispense_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned DISPENSE_CYCLES = 150000000,
    parameter int unsigned COOLDOWN_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_raw,
    input  logic       cup_raw,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    output logic       activate,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [1:0] state_dbg
);

    localparam int unsigned MAX_AB = (DEBOUNCE_CYCLES > DISPENSE_CYCLES) ? DEBOUNCE_CYCLES : DISPENSE_CYCLES;
    localparam int unsigned MAX_P  = (MAX_AB > COOLDOWN_CYCLES) ? MAX_AB : COOLDOWN_CYCLES;
    localparam int CW = $clog2(MAX_P + 1);

    // Terminal values: an event fires on the cycle the counter holds N-1,
    // so the event takes effect on the N-th clock edge.
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DISP_LAST = CW'(DISPENSE_CYCLES - 1);
    localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPENSE = 2'd1,
        ST_COOLDOWN = 2'd2,
        ST_FAULT    = 2'd3
    } state_t;

    logic          btn_meta_r, btn_sync_r, cup_meta_r, cup_sync_r;
    logic          btn_db_r, btn_db_prev_r, cup_db_r;
    logic [CW-1:0] btn_cnt_r, cup_cnt_r, cnt_r;
    state_t        state_r, state_n;
    logic          cnt_clr_s, done_n_s, btn_rise_s, start_req_s;
    logic          activate_r, busy_r, done_r, fault_r;

    // Two-flop synchronisers for the asynchronous button and cup inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_r <= 1'b0;
            btn_sync_r <= 1'b0;
            cup_meta_r <= 1'b0;
            cup_sync_r <= 1'b0;
        end else begin
            btn_meta_r <= btn_raw;
            btn_sync_r <= btn_meta_r;
            cup_meta_r <= cup_raw;
            cup_sync_r <= cup_meta_r;
        end
    end

    // Button debouncer: flip after DEBOUNCE_CYCLES consecutive disagreeing cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_db_r  <= 1'b0;
            btn_cnt_r <= {CW{1'b0}};
        end else if (btn_sync_r != btn_db_r) begin
            if (btn_cnt_r == DEB_LAST) begin
                btn_db_r  <= btn_sync_r;
                btn_cnt_r <= {CW{1'b0}};
            end else begin
                btn_cnt_r <= btn_cnt_r + CNT_ONE;
            end
        end else begin
            btn_cnt_r <= {CW{1'b0}};
        end
    end

    // Cup debouncer: same rule as the button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cup_db_r  <= 1'b0;
            cup_cnt_r <= {CW{1'b0}};
        end else if (cup_sync_r != cup_db_r) begin
            if (cup_cnt_r == DEB_LAST) begin
                cup_db_r  <= cup_sync_r;
                cup_cnt_r <= {CW{1'b0}};
            end else begin
                cup_cnt_r <= cup_cnt_r + CNT_ONE;
            end
        end else begin
            cup_cnt_r <= {CW{1'b0}};
        end
    end

    // Previous debounced button level for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_db_prev_r <= 1'b0;
        end else begin
            btn_db_prev_r <= btn_db_r;
        end
    end

    // A held button gives one edge only, so it never retriggers.
    // A command pulse together with that edge still counts as one start.
    assign btn_rise_s  = btn_db_r & ~btn_db_prev_r;
    assign start_req_s = btn_rise_s | cmd_start;

    // Next-state logic; cup loss outranks stop, and stop outranks completion
    always_comb begin
        state_n   = state_r;
        cnt_clr_s = 1'b0;
        done_n_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_req_s && cup_db_r) begin
                    state_n   = ST_DISPENSE;
                    cnt_clr_s = 1'b1;
                end else begin
                    state_n   = ST_IDLE;
                end
            end
            ST_DISPENSE: begin
                if (!cup_db_r) begin
                    state_n   = ST_FAULT;
                    cnt_clr_s = 1'b1;
                end else if (cmd_stop) begin
                    state_n   = ST_COOLDOWN;
                    cnt_clr_s = 1'b1;
                end else if (cnt_r == DISP_LAST) begin
                    state_n   = ST_COOLDOWN;
                    cnt_clr_s = 1'b1;
                    done_n_s  = 1'b1;
                end else begin
                    state_n   = ST_DISPENSE;
                end
            end
            ST_COOLDOWN: begin
                if (cnt_r == COOL_LAST) begin
                    state_n   = ST_IDLE;
                    cnt_clr_s = 1'b1;
                end else begin
                    state_n   = ST_COOLDOWN;
                end
            end
            ST_FAULT: begin
                if (cmd_stop || btn_rise_s) begin
                    state_n   = ST_COOLDOWN;
                    cnt_clr_s = 1'b1;
                end else begin
                    state_n   = ST_FAULT;
                end
            end
            default: begin
                state_n   = ST_IDLE;
                cnt_clr_s = 1'b1;
            end
        endcase
    end

    // State register, dwell counter and registered outputs.
    // The counter is cleared on every state change. It only counts in the
    // timed states and is cleared at its terminal value, so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CW{1'b0}};
            activate_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            fault_r    <= 1'b0;
        end else begin
            state_r <= state_n;
            if (cnt_clr_s) begin
                cnt_r <= {CW{1'b0}};
            end else if ((state_r == ST_DISPENSE) || (state_r == ST_COOLDOWN)) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
            activate_r <= (state_n == ST_DISPENSE);
            busy_r     <= (state_n != ST_IDLE);
            done_r     <= done_n_s;
            fault_r    <= (state_n == ST_FAULT);
        end
    end

    assign activate  = activate_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign fault     = fault_r;
    assign state_dbg = state_r;

endmodule

// File: tb/tb_dispense_sequencer.sv
// Self-checking bench for dispense_sequencer with small timing parameters.
// A reference model tracks the phase and entry time of each phase.
// It checks every output on every cycle. Directed scenarios add literal
// latency and duration expectations. A randomized phase follows them.
module tb_dispense_sequencer;

    localparam int D = 4;
    localparam int N = 20;
    localparam int C = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_raw = 1'b0;
    logic       cup_raw = 1'b0;
    logic       cmd_start = 1'b0;
    logic       cmd_stop = 1'b0;
    logic       activate, busy, done, fault;
    logic [1:0] state_dbg;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dispense_sequencer #(
        .DEBOUNCE_CYCLES(D),
        .DISPENSE_CYCLES(N),
        .COOLDOWN_CYCLES(C)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_raw(btn_raw),
        .cup_raw(cup_raw),
        .cmd_start(cmd_start),
        .cmd_stop(cmd_stop),
        .activate(activate),
        .busy(busy),
        .done(done),
        .fault(fault),
        .state_dbg(state_dbg)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state.
    // Phase numbering: 0 idle, 1 dispensing, 2 cooldown, 3 fault.
    int   cyc = 0;
    int   m_phase = 0;
    int   m_t = 0;
    logic m_done = 1'b0;
    logic bh [0:D+1];
    logic ch [0:D+1];
    logic m_bdb = 1'b0, m_bdb_prev = 1'b0, m_cdb = 1'b0;
    logic s_b, s_c, s_s, s_p, m_rise, m_start, m_bflip, m_cflip;

    // Model step at each rising edge, then compare every output 1 time unit later
    always @(posedge clk) begin
        s_b = btn_raw;
        s_c = cup_raw;
        s_s = cmd_start;
        s_p = cmd_stop;
        cyc = cyc + 1;
        if (!rst_n) begin
            m_phase    = 0;
            m_done     = 1'b0;
            m_bdb      = 1'b0;
            m_bdb_prev = 1'b0;
            m_cdb      = 1'b0;
            for (int i = 0; i < D + 2; i++) begin
                bh[i] = 1'b0;
                ch[i] = 1'b0;
            end
        end else begin
            m_rise  = m_bdb && !m_bdb_prev;
            m_start = m_rise || s_s;
            m_done  = 1'b0;
            case (m_phase)
                0: if (m_start && m_cdb) begin m_phase = 1; m_t = cyc; end
                1: begin
                    if (!m_cdb) begin
                        m_phase = 3; m_t = cyc;
                    end else if (s_p) begin
                        m_phase = 2; m_t = cyc;
                    end else if (cyc - m_t == N) begin
                        m_phase = 2; m_t = cyc; m_done = 1'b1;
                    end
                end
                2: if (cyc - m_t == C) begin m_phase = 0; m_t = cyc; end
                default: if (s_p || m_rise) begin m_phase = 2; m_t = cyc; end
            endcase
            // Raw-sample history: entry i is the sample taken i edges ago.
            // Each debounced level flips once the last D synchronised samples
            // all disagree with it. Those are the raw samples 2..D+1 edges back.
            for (int i = D + 1; i > 0; i--) begin
                bh[i] = bh[i-1];
                ch[i] = ch[i-1];
            end
            bh[0] = s_b;
            ch[0] = s_c;
            m_bflip = 1'b1;
            m_cflip = 1'b1;
            for (int i = 2; i <= D + 1; i++) begin
                if (bh[i] == m_bdb) m_bflip = 1'b0;
                if (ch[i] == m_cdb) m_cflip = 1'b0;
            end
            m_bdb_prev = m_bdb;
            if (m_bflip) m_bdb = !m_bdb;
            if (m_cflip) m_cdb = !m_cdb;
        end
        #1;
        chk("model_activate", int'(activate), int'(m_phase == 1));
        chk("model_busy", int'(busy), int'(m_phase != 0));
        chk("model_done", int'(done), int'(m_done));
        chk("model_fault", int'(fault), int'(m_phase == 3));
        chk("model_state", int'(state_dbg), m_phase);
    end

    initial begin
        int   n;
        logic any_act;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cup_raw = 1'b1;
        repeat (12) @(negedge clk);
        chk("idle_state", int'(state_dbg), 0);
        chk("idle_busy", int'(busy), 0);

        // Button held: latency, dispense length, done, cooldown, no retrigger
        btn_raw = 1'b1;
        n = 0;
        while (!activate && n < 50) begin @(negedge clk); n++; end
        chk("btn_to_activate", n, 7);
        n = 0;
        while (activate && n < 50) begin @(negedge clk); n++; end
        chk("dispense_len", n, 20);
        chk("done_at_fall", int'(done), 1);
        @(negedge clk);
        chk("done_one_cycle", int'(done), 0);
        n = 1;
        while (busy && n < 50) begin @(negedge clk); n++; end
        chk("cooldown_len", n, 10);
        any_act = 1'b0;
        repeat (15) begin @(negedge clk); any_act |= activate; end
        chk("no_retrigger_held", int'(any_act), 0);
        btn_raw = 1'b0;
        repeat (10) @(negedge clk);

        // Short button glitches never pass the debouncer
        any_act = 1'b0;
        repeat (10) begin
            btn_raw = 1'b1;
            repeat (2) begin @(negedge clk); any_act |= activate | busy; end
            btn_raw = 1'b0;
            repeat (2) begin @(negedge clk); any_act |= activate | busy; end
        end
        repeat (8) begin @(negedge clk); any_act |= activate | busy; end
        chk("glitch_no_dispense", int'(any_act), 0);

        // No cup: start ignored; cup settles, then command starts next cycle
        cup_raw = 1'b0;
        repeat (10) @(negedge clk);
        cmd_start = 1'b1; @(negedge clk); cmd_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("nocup_state", int'(state_dbg), 0);
        chk("nocup_activate", int'(activate), 0);
        cup_raw = 1'b1;
        repeat (7) @(negedge clk);
        cmd_start = 1'b1; @(negedge clk); cmd_start = 1'b0;
        chk("cmd_start_latency", int'(activate), 1);
        chk("cmd_start_state", int'(state_dbg), 1);

        // Cup removed at dispense cycle 8 -> fault, then stop -> cooldown
        repeat (7) @(negedge clk);
        cup_raw = 1'b0;
        n = 0;
        while (activate && n < 50) begin @(negedge clk); n++; end
        chk("cup_fall_latency", n, 7);
        chk("fault_flag", int'(fault), 1);
        chk("fault_state", int'(state_dbg), 3);
        chk("fault_no_done", int'(done), 0);
        repeat (3) @(negedge clk);
        cup_raw = 1'b1;
        cmd_stop = 1'b1; @(negedge clk); cmd_stop = 1'b0;
        chk("fault_exit_state", int'(state_dbg), 2);
        chk("fault_exit_flag", int'(fault), 0);
        n = 0;
        while (busy && n < 50) begin @(negedge clk); n++; end
        chk("fault_cooldown_len", n, 10);
        repeat (10) @(negedge clk);

        // Stop at dispense cycle 5; start during cooldown is dropped
        cmd_start = 1'b1; @(negedge clk); cmd_start = 1'b0;
        chk("stop_test_start", int'(activate), 1);
        repeat (4) @(negedge clk);
        cmd_stop = 1'b1; @(negedge clk); cmd_stop = 1'b0;
        chk("stop_drops_activate", int'(activate), 0);
        chk("stop_no_done", int'(done), 0);
        chk("stop_state", int'(state_dbg), 2);
        repeat (2) @(negedge clk);
        cmd_start = 1'b1; @(negedge clk); cmd_start = 1'b0;
        n = 3;
        while (busy && n < 50) begin @(negedge clk); n++; end
        chk("stop_cooldown_len", n, 10);
        repeat (5) @(negedge clk);
        chk("cooldown_start_ignored", int'(state_dbg), 0);

        // Reset at dispense cycle 10 drops everything immediately
        cmd_start = 1'b1; @(negedge clk); cmd_start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_reset_activate", int'(activate), 1);
        rst_n = 1'b0;
        #1;
        chk("reset_activate", int'(activate), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_fault", int'(fault), 0);
        chk("reset_state", int'(state_dbg), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        any_act = 1'b0;
        repeat (30) begin @(negedge clk); any_act |= activate; end
        chk("no_spontaneous", int'(any_act), 0);

        // Randomized traffic against the model
        repeat (3000) begin
            @(negedge clk);
            if ($urandom_range(0, 11) == 0) btn_raw = !btn_raw;
            if ($urandom_range(0, 39) == 0) cup_raw = !cup_raw;
            cmd_start = ($urandom_range(0, 14) == 0);
            cmd_stop  = ($urandom_range(0, 29) == 0);
            rst_n     = ($urandom_range(0, 799) != 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cmd_start = 1'b0;
        cmd_stop = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/dispense_sequencer.md
Name: dispense_sequencer

Overview:
- Generates the `activate` request consumed by the valve relay stage (relay_controller via top_rele); sits directly upstream of it.
- Replaces the direct switch-to-activate wiring with a timed, interlocked dispense cycle.
- Start sources: push button (synchronised and debounced) or a one-cycle command pulse from a future UART decoder.
- Interlock: a debounced cup-present sensor gates every dispense.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a new level on btn or cup (10 ms at 50 MHz); must be >= 1.
- DISPENSE_CYCLES, 150000000, cycles `activate` is held high for a full dispense (3 s at 50 MHz); must be >= 1.
- COOLDOWN_CYCLES, 50000000, minimum cycles `activate` stays low after any dispense ends (1 s); must be >= 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- btn_raw  input  1  raw push button, asynchronous, active high
- cup_raw  input  1  raw cup-present sensor, asynchronous, high = cup present
- cmd_start  input  1  synchronous one-cycle start request
- cmd_stop  input  1  synchronous one-cycle stop/clear request
- activate  output  1  to relay_controller.activate; high = open valve
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse on normal dispense completion
- fault  output  1  high while in FAULT
- state_dbg  output  2  IDLE=0, DISPENSE=1, COOLDOWN=2, FAULT=3

Behaviour:
- Reset (async assert, sync release via clk) values:
  - activate=0, busy=0, done=0, fault=0, state=IDLE.
  - Synchroniser flops=0, debounced btn_db=0, cup_db=0, all counters=0.
- Input conditioning:
  - btn_raw and cup_raw each pass through a 2-flop synchroniser.
  - Each debouncer flips its output after the synchronised value differs from the current output for DEBOUNCE_CYCLES consecutive cycles.
  - Any agreeing cycle restarts that count.
- start_req = (rising edge of btn_db) OR cmd_start. It is edge-only: a held button never retriggers.
- Counter width: $clog2(max param + 1). No counter wraps; each is cleared on state entry.
- FSM, all outputs registered:
  - IDLE:
    - start_req AND cup_db -> DISPENSE.
    - start_req with cup_db=0 is ignored.
  - DISPENSE:
    - activate=1 for exactly DISPENSE_CYCLES cycles.
    - Priority order: cup_db falls -> FAULT; else cmd_stop -> COOLDOWN (no done); else count reaches DISPENSE_CYCLES -> COOLDOWN with done=1 for that one cycle.
  - COOLDOWN:
    - activate=0 for exactly COOLDOWN_CYCLES cycles, then -> IDLE.
    - start_req and cmd_stop are ignored, not queued.
  - FAULT:
    - activate=0, fault=1.
    - Exit on cmd_stop OR btn_db rising edge -> COOLDOWN (cooldown is always enforced).
    - Cup state does not matter for the exit.
- Latency:
  - btn_raw rise to activate rise = 2 + DEBOUNCE_CYCLES + 1 cycles.
  - cmd_start to activate = 1 cycle.
  - cup_raw fall to activate fall = 2 + DEBOUNCE_CYCLES + 1 cycles.
- Simultaneous events in DISPENSE:
  - cup fall with cmd_stop -> FAULT.
  - cup fall or cmd_stop on the final count cycle -> FAULT or COOLDOWN respectively, done=0.
- Simultaneous start sources in IDLE: cmd_start and a button edge together count as a single start.
- Reset mid-dispense drops activate asynchronously in the same instant.
- Output guarantees:
  - activate is glitch-free: driven directly from a flop.
  - activate is never high outside DISPENSE.

Test Plan (bench params DEBOUNCE=4, DISPENSE=20, COOLDOWN=10):
- Cup present; btn_raw held high for 30 cycles -> activate rises 7 cycles after btn_raw rise and stays high 20 cycles; done pulses 1 cycle at the fall; busy low 10 cycles after the fall; no second dispense while the button is still held.
- btn_raw 2-cycle glitches repeated 10 times -> btn_db stays 0, activate never asserts.
- cup_db=0, cmd_start pulse -> remains IDLE, activate=0; then set cup high, wait 7 cycles, pulse cmd_start -> activate high next cycle.
- Mid-dispense (cycle 8), cup_raw drops -> activate falls 7 cycles later, fault=1, state_dbg=3, done=0; cmd_stop -> COOLDOWN for 10 cycles, then IDLE.
- cmd_stop at DISPENSE cycle 5 -> activate falls next cycle, done=0; cmd_start during COOLDOWN -> ignored, IDLE reached after 10 cycles.
- rst_n pulled low at DISPENSE cycle 10 -> activate=0 immediately, all outputs at reset values; after release, no spontaneous dispense.
